// File: rtl/memory_page_reader.sv
// memory_page_reader
//
// Reads one page from the paged Memory block. The sequence is:
//   1. A dummy read refreshes the page's entry count.
//   2. The count is latched.
//   3. Addresses 0 .. count-1 are issued.
// Returning data passes through a small skid FIFO and leaves as a
// valid/ready stream, with m_last on the final entry.
//
// The memory read latency is tracked with a shift register of tag bits that
// travels alongside each read. A read is issued only when there is
// guaranteed room for its data, counting both data already in the FIFO and
// data still in flight. This lets the FIFO absorb any amount of backpressure
// without overflowing.
//
// Ports:
//   clkb, rstb_n        clock (rising edge), asynchronous active-low reset
//   start, start_page   single-cycle request and page to read; taken only when idle
//   busy, done          busy from the cycle after start until the done pulse, inclusive
//   addrb, pageb, enb,  Memory read port controls
//   regceb
//   doutb, nent         Memory read data and per-page entry count
//   m_data, m_valid,    output stream; m_last marks the final entry
//   m_ready, m_last
module memory_page_reader #(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int PAGE_W       = 1,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = READ_LATENCY + 2,
  localparam int AW          = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clkb,
  input  logic                 rstb_n,
  input  logic                 start,
  input  logic [PAGE_W-1:0]    start_page,
  output logic                 busy,
  output logic                 done,
  output logic [AW-1:0]        addrb,
  output logic [PAGE_W-1:0]    pageb,
  output logic                 enb,
  output logic                 regceb,
  input  logic [RAM_WIDTH-1:0] doutb,
  input  logic [4:0]           nent,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);

  typedef enum logic [2:0] {IDLE, COUNT, SAMPLE, READ, DRAIN} state_t;

  // Counters hold outstanding + fifo_count without wrapping.
  localparam int CW = $clog2(2 * FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  state_t                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [4:0]            rd_addr_q, rd_addr_d;
  logic [PAGE_W-1:0]     pageb_q, pageb_d;
  logic                  done_q, done_d;
  logic                  regceb_q;

  // occ marks any read in flight, including the dummy count read.
  // vld marks reads whose data must be pushed. lst marks the final entry.
  logic [READ_LATENCY-1:0] occ_q, vld_q, lst_q;
  logic                    issue_vld, issue_lst;

  logic [RAM_WIDTH-1:0]  fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         fifo_count_q;
  logic [CW-1:0]         outstanding;
  logic                  push, pop, room;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push    = vld_q[READ_LATENCY-1];
  assign m_valid = (fifo_count_q != '0);
  assign pop     = m_valid & m_ready;
  assign m_data  = fifo_data_q[rd_ptr_q];
  assign m_last  = fifo_last_q[rd_ptr_q];
  assign pageb   = pageb_q;
  assign done    = done_q;
  assign regceb  = regceb_q;
  assign busy    = (state_q != IDLE) | done_q;

  // Count the in-flight reads that will push into the FIFO.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      outstanding = outstanding + CW'(vld_q[i]);
    end
  end

  assign room = (outstanding + fifo_count_q) < CW'(FIFO_DEPTH);

  // Next-state logic and read-port drive.
  // The done pulse is raised one cycle early: when the final beat is being
  // accepted, done lands in the cycle right after the m_last handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    pageb_d   = pageb_q;
    done_d    = 1'b0;
    enb       = 1'b0;
    addrb     = '0;
    issue_vld = 1'b0;
    issue_lst = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          pageb_d = start_page;
          state_d = COUNT;
        end
      end
      COUNT: begin
        enb     = 1'b1;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        cnt_d     = nent;
        rd_addr_d = '0;
        state_d   = (nent != 5'd0) ? READ : DRAIN;
      end
      READ: begin
        if (rd_addr_q < cnt_q) begin
          if (room) begin
            enb       = 1'b1;
            addrb     = AW'(rd_addr_q);
            issue_vld = 1'b1;
            issue_lst = (rd_addr_q == cnt_q - 5'd1);
            rd_addr_d = rd_addr_q + 5'd1;
            if (rd_addr_q + 5'd1 == cnt_q) begin
              state_d = DRAIN;
            end
          end
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((occ_q == '0) &&
            ((fifo_count_q == '0) || ((fifo_count_q == CW'(1)) && pop))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  // After reset release, regceb is held at 1.
  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      pageb_q   <= '0;
      done_q    <= 1'b0;
      regceb_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      pageb_q   <= pageb_d;
      done_q    <= done_d;
      regceb_q  <= 1'b1;
    end
  end

  // Tag pipe.
  // The last stage lines up with the cycle in which doutb holds that
  // read's data. Reset clears the pipe, so any data that arrives late is
  // dropped.
  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      occ_q <= '0;
      vld_q <= '0;
      lst_q <= '0;
    end else begin
      for (int i = 1; i < READ_LATENCY; i++) begin
        occ_q[i] <= occ_q[i-1];
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
      occ_q[0] <= enb;
      vld_q[0] <= issue_vld;
      lst_q[0] <= issue_lst;
    end
  end

  // Show-ahead skid FIFO.
  // The issue rule ensures a push never finds the FIFO full.
  always_ff @(posedge clkb or negedge rstb_n) begin
    if (!rstb_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= doutb;
        fifo_last_q[wr_ptr_q] <= lst_q[READ_LATENCY-1];
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      fifo_count_q <= fifo_count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: doc/memory_page_reader.md
# memory_page_reader

Read-side sequencer for the paged `Memory` block. On a start request it fetches the entry count of one page and issues read addresses `0 .. nent-1`. It absorbs the memory's fixed read latency and delivers the entries as a valid/ready stream with `m_last` on the final entry. It sits between the `Memory` read port (`addrb`/`pageb`/`enb`/`regceb`/`doutb`/`nent_0`) and the downstream consumer.

## Interface
- `RAM_WIDTH`, 18, data width; matches `Memory`.
- `RAM_DEPTH`, 1024, entries per page; `AW = clogb2(RAM_DEPTH)`.
- `PAGE_W`, 1, page select width; matches the `Memory` `pageb` width.
- `READ_LATENCY`, 2, cycles from `enb` to valid `doutb`: 2 for HIGH_PERFORMANCE, 1 for LOW_LATENCY.
- `FIFO_DEPTH`, `READ_LATENCY+2`, output skid FIFO depth.

Ports:
- `clkb` in 1: the single clock, rising edge; also drives the `Memory` `clkb`.
- `rstb_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request, sampled only in IDLE.
- `start_page` in `PAGE_W`: page to read, captured with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until the `done` cycle, inclusive.
- `done` out 1: one-cycle pulse when the page is fully delivered.
- `addrb` out `AW`: memory read address.
- `pageb` out `PAGE_W`: memory read page.
- `enb` out 1: memory read enable, one read per high cycle.
- `regceb` out 1: memory output register enable.
- `doutb` in `RAM_WIDTH`: memory read data.
- `nent` in 5: per-page entry count from `Memory` `nent_0`. Valid the cycle after an `enb` on that page.
- `m_data` out `RAM_WIDTH`: stream data.
- `m_valid` out 1: stream valid.
- `m_ready` in 1: stream ready.
- `m_last` out 1: marks the final entry of the page.

## Operation
- **Reset values:** all registered outputs 0 (`addrb`, `pageb`, `enb`, `regceb`, `busy`, `done`, `m_valid`, `m_last`, `m_data`). `regceb` goes to 1 on the first clock after reset release and stays 1.
- **States:** IDLE, COUNT, SAMPLE, READ, DRAIN.
- **IDLE:**
  - `start`=1 latches `start_page` into `pageb` and moves to COUNT.
  - `start` is ignored in every other state; there is no queuing.
- **COUNT:**
  - `enb`=1 with `addrb`=0 for exactly one cycle. This is a dummy read that only refreshes `nent`.
  - Its data is tagged invalid and never pushed.
  - Moves to SAMPLE.
- **SAMPLE:**
  - Latches `nent` into `cnt` (5 bits) and clears `rd_addr`.
  - Moves to READ if `cnt`≠0, otherwise to DRAIN.
- **READ:**
  - Issue condition: `rd_addr` < `cnt` and `outstanding` + `fifo_count` < `FIFO_DEPTH`.
  - When the condition holds, `enb`=1 with `addrb`=`rd_addr`, and `rd_addr` increments.
  - When `rd_addr` = `cnt`, move to DRAIN.
- **DRAIN:**
  - Wait until the tag pipe is empty, `outstanding`=0, and the FIFO is empty with its last beat accepted.
  - Then pulse `done` and return to IDLE.
- **Tag pipe:**
  - A `READ_LATENCY`-deep shift register of valid bits marks which `doutb` cycles carry real data.
  - `outstanding` is the number of set bits.
- **FIFO push:**
  - When a tag emerges, `doutb` is pushed with `last` = (its address = `cnt`-1).
  - The issue rule guarantees the FIFO never overflows.
- **FIFO output:**
  - Show-ahead; `m_valid` = FIFO non-empty.
  - A pop occurs on `m_valid` & `m_ready`.
  - `m_data` and `m_last` must hold stable while `m_valid` & !`m_ready`.
- **Address width:** addresses never exceed 30, because `cnt` ≤ 31. `addrb` is zero-extended to `AW`.
- **Reset mid-operation:** go to IDLE, clear the FIFO, the tag pipe, `cnt`, and `done`. Late memory data is discarded.

## Timing
- For `start` in cycle 0:
  - COUNT is cycle 1.
  - SAMPLE is cycle 2.
  - The first READ issue is cycle 3.
  - First `doutb` is valid in cycle 3+`READ_LATENCY` and is pushed at the end of that cycle.
  - First `m_valid` is in cycle 4+`READ_LATENCY` (cycle 6 for L=2).
- **Throughput:** with `m_ready` held 1, `enb` is high every READ cycle and `m_valid` is continuous. An N-entry page ends with `done` in cycle N+4+`READ_LATENCY`, which is the cycle after the `m_last` handshake.
- **Zero-entry page (`cnt`=0):** no beats. DRAIN waits for the dummy tag to clear; `done` in cycle 3+`READ_LATENCY`.
- **Backpressure:**
  - Issue stalls once `outstanding` + `fifo_count` = `FIFO_DEPTH`.
  - Issue resumes the cycle after a pop.
  - No data is lost or duplicated.
- **Restart:** `busy` is low in the cycle after `done`, so a `start` in that cycle is accepted.

## Test plan
- **Basic page:** page 0 written with `nent`=5, data 0x100..0x104; `start` with `start_page`=0, `m_ready`=1 -> beats 0x100..0x104 in cycles 6..10, `m_last` only on 0x104, `done` in cycle 11.
- **Backpressure:** 8 entries on page 1; `m_ready` toggles 1,0,0,1 repeating -> all 8 values in order, `m_data` stable during stalls, `outstanding` + `fifo_count` ≤ 4 at all times, exactly one `m_last`.
- **Empty page:** `nent`=0; `start` -> no `m_valid`, only the single COUNT `enb`, `done` in cycle 5.
- **Start while busy:** `start` pulsed again mid-READ with a different page -> ignored, `pageb` unchanged, one `done` only; a `start` in the cycle after `done` is accepted.
- **Reset mid-read:** `rstb_n` asserted low with 2 reads in flight, then released -> all outputs 0, no stale `m_valid` afterwards, next `start` reads the full page correctly.
- **Full rate, maximum count:** `nent`=31 on page 1 with `READ_LATENCY`=1 and 2 -> 31 consecutive beats, addresses 0..30, `done` at cycle 35+`READ_LATENCY`.
